// File: rtl/bmu_wb_pkg.sv
// Shared types for the BMU writeback buffer: the buffered entry payload
// and the rule that decides whether an aligned result is worth writing back.
package bmu_wb_pkg;

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              err;
  } bmu_wb_entry_t;

  // Writes to x0 are meaningless unless they carry an error that must be reported.
  function automatic logic entry_wanted(input logic [RD_W-1:0] rd, input logic err);
    return (rd != '0) || err;
  endfunction

endpackage

// File: rtl/bmu_wb_fifo.sv
// Synchronous FIFO of writeback entries. The head is read combinationally
// and forced to zero when empty; a push into a full FIFO succeeds only with a same-cycle pop.
module bmu_wb_fifo
  import bmu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 push,
  input  bmu_wb_entry_t        push_data,
  input  logic                 pop,
  input  logic                 flush,
  output bmu_wb_entry_t        head,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  bmu_wb_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy state; flush takes priority over any push/pop.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: stale slots are never visible through the head mux.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bmu_wb_buffer.sv
// Writeback buffer behind the BMU: aligns destination tags with the delayed
// result, filters x0 writes, queues entries and throttles issue so the queue cannot overflow.
module bmu_wb_buffer
  import bmu_wb_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ERRW    = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              valid_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              flush,
  input  logic [DATA_W-1:0] result_ff,
  input  logic              error,
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
  output logic              issue_stall,
  output logic              overflow,
  output logic [ERRW-1:0]   err_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W = $clog2(LATENCY + 1);
  localparam int unsigned SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  logic [LATENCY-1:0] tag_v;
  logic [RD_W-1:0]    tag_rd [LATENCY];
  logic               cand_v;
  logic [RD_W-1:0]    cand_rd;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_accept;
  logic               fifo_drop;
  bmu_wb_entry_t      push_entry;
  bmu_wb_entry_t      head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INF_W-1:0]   inflight;
  logic [SUM_W-1:0]   occupancy;

  // Tag pipe: one {v, rd} stage per cycle of BMU latency.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tag_v <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) tag_rd[i] <= '0;
    end else begin
      tag_v[0]  <= valid_in && !flush;
      tag_rd[0] <= rd_in;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1] && !flush;
        tag_rd[i] <= tag_rd[i-1];
      end
    end
  end

  assign cand_v  = tag_v[LATENCY-1];
  assign cand_rd = tag_rd[LATENCY-1];

  assign push_entry  = '{rd: cand_rd, data: result_ff, err: error};
  assign fifo_push   = cand_v && entry_wanted(cand_rd, error) && !flush;
  assign fifo_pop    = !fifo_empty && wb_ready && !flush;
  assign fifo_accept = fifo_push && (!fifo_full || fifo_pop);
  assign fifo_drop   = fifo_push && fifo_full && !fifo_pop;

  bmu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wb_valid = !fifo_empty;
  assign wb_rd    = head.rd;
  assign wb_data  = head.data;
  assign wb_err   = head.err;

  // Ops already issued but not yet landed in the FIFO still need a slot.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) inflight = inflight + INF_W'(tag_v[i]);
  end

  assign occupancy   = SUM_W'(fifo_count) + SUM_W'(inflight);
  assign issue_stall = (occupancy >= SUM_W'(DEPTH));

  // Sticky drop flag and saturating error tally; both survive flush.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (fifo_drop) overflow <= 1'b1;
      if (fifo_accept && error && (err_count != '1)) err_count <= err_count + ERRW'(1);
    end
  end

endmodule

// File: tb/tb_bmu_wb_buffer.sv
// Bench for bmu_wb_buffer: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_bmu_wb_buffer;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int ERRW  = 16;
  localparam int EC_MAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rst_l;
  logic            valid_in;
  logic [4:0]      rd_in;
  logic            flush;
  logic [31:0]     result_ff;
  logic            error;
  logic            wb_ready;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_data;
  logic            wb_err;
  logic            issue_stall;
  logic            overflow;
  logic [ERRW-1:0] err_count;

  always #5 clk = ~clk;

  bmu_wb_buffer #(.DEPTH(DEPTH), .LATENCY(LAT), .ERRW(ERRW)) dut (
    .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .rd_in(rd_in), .flush(flush),
    .result_ff(result_ff), .error(error), .wb_ready(wb_ready), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err), .issue_stall(issue_stall),
    .overflow(overflow), .err_count(err_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the queue of buffered entries plus the list of issued ops awaiting their result.
  typedef struct {logic [4:0] rd; logic [31:0] data; logic err;} ent_t;
  ent_t       mq[$];
  int         iss_edge[$];
  logic [4:0] iss_rd[$];
  int         ecnt  = 0;
  bit         m_ovf = 0;
  int         m_ec  = 0;

  typedef struct {
    logic v; logic [4:0] rd; logic [31:0] res; logic err; logic rdy;
    logic ev; logic [4:0] erd; logic [31:0] edata; logic eerr; logic estall; logic [15:0] eec;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    return (mq.size() + iss_edge.size()) >= DEPTH;
  endfunction

  task automatic model_reset();
    mq.delete(); iss_edge.delete(); iss_rd.delete();
    m_ovf = 0; m_ec = 0;
  endtask

  task automatic model_edge();
    bit cand, full, pop, do_push;
    logic [4:0] rdc;
    ent_t e;
    do_push = 0;
    cand = (iss_edge.size() != 0) && (iss_edge[0] == ecnt - LAT);
    if (flush) begin
      mq.delete(); iss_edge.delete(); iss_rd.delete();
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && wb_ready;
      if (cand) begin
        rdc = iss_rd.pop_front();
        void'(iss_edge.pop_front());
        if (rdc != 0 || error) begin
          if (full && !pop) m_ovf = 1;
          else begin
            e = '{rdc, result_ff, error};
            do_push = 1;
            if (error && m_ec < EC_MAX) m_ec++;
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
      if (valid_in) begin iss_edge.push_back(ecnt); iss_rd.push_back(rd_in); end
    end
    ecnt++;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] res,
                       input logic err, input logic rdy, input logic fl);
    @(negedge clk);
    valid_in = v; rd_in = rd; result_ff = res; error = err; wb_ready = rdy; flush = fl;
    #1;
  endtask

  task automatic check_model();
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '{5'd0, 32'd0, 1'b0};
    chk("wb_valid",    32'(wb_valid),    32'(mq.size() != 0));
    chk("wb_rd",       32'(wb_rd),       32'(h.rd));
    chk("wb_data",     wb_data,          h.data);
    chk("wb_err",      32'(wb_err),      32'(h.err));
    chk("issue_stall", 32'(issue_stall), 32'(m_stall()));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("err_count",   32'(err_count),   32'(m_ec));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input logic v, input logic [4:0] rd, input logic [31:0] res,
                     input logic err, input logic rdy, input logic fl);
    drive(v, rd, res, err, rdy, fl);
    check_model();
    tick();
  endtask

  task automatic pop_expect(input logic [4:0] erd, input logic [31:0] edata);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("drain_rd", 32'(wb_rd), 32'(erd));
    chk("drain_data", wb_data, edata);
    check_model();
    tick();
  endtask

  // Four back-to-back issues with result k arriving one cycle after rd k.
  task automatic fill4();
    cyc(1'b1, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd2, 32'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd3, 32'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd4, 32'd3, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors: latency, x0 filtering, error entry, hold under backpressure.
    tbl[0] = '{1'b1, 5'd5, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 5'd0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'd0};
    tbl[3] = '{1'b1, 5'd0, 32'h1234,      1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 16'd0};
    tbl[4] = '{1'b0, 5'd0, 32'h0BAD,      1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 16'd0};
    tbl[5] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd0, 32'h0BAD,      1'b1, 1'b0, 16'd1};
    tbl[6] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd0, 32'h0BAD,      1'b1, 1'b0, 16'd1};
    tbl[7] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 16'd1};

    rst_l = 1'b0; valid_in = 1'b0; rd_in = '0; flush = 1'b0;
    result_ff = '0; error = 1'b0; wb_ready = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_stall", 32'(issue_stall), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_l = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].res, tbl[i].err, tbl[i].rdy, 1'b0);
      chk($sformatf("vec%0d_wb_valid", i), 32'(wb_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_wb_rd", i), 32'(wb_rd), 32'(tbl[i].erd));
      chk($sformatf("vec%0d_wb_data", i), wb_data, tbl[i].edata);
      chk($sformatf("vec%0d_wb_err", i), 32'(wb_err), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_stall", i), 32'(issue_stall), 32'(tbl[i].estall));
      chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(tbl[i].eec));
      tick();
    end

    // Backpressure: stall after the 4th issue, then in-order drain.
    fill4();
    chk("bp_stall_after_4", 32'(issue_stall), 32'd1);
    cyc(1'b0, 5'd0, 32'd4, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) pop_expect(5'(k), 32'(k));
    chk("bp_empty", 32'(wb_valid), 32'd0);

    // Push while full with a same-cycle pop.
    fill4();
    chk("full_stall", 32'(issue_stall), 32'd1);
    cyc(1'b1, 5'd7, 32'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd7, 1'b0, 1'b1, 1'b0);
    chk("full_pp_overflow", 32'(overflow), 32'd0);
    chk("full_pp_valid", 32'(wb_valid), 32'd1);
    pop_expect(5'd2, 32'd2);
    pop_expect(5'd3, 32'd3);
    pop_expect(5'd4, 32'd4);
    pop_expect(5'd7, 32'd7);
    chk("full_pp_empty", 32'(wb_valid), 32'd0);

    // Push while full without a pop is dropped and sets overflow.
    fill4();
    cyc(1'b1, 5'd9, 32'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd9, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) pop_expect(5'(k), 32'(k));
    chk("ovf_rd9_dropped", 32'(wb_valid), 32'd0);

    // Flush with two queued and one in flight; counters retained.
    cyc(1'b1, 5'd10, 32'd0,  1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd11, 32'd10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd12, 32'd11, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_valid", 32'(wb_valid), 32'd1);
    cyc(1'b0, 5'd0, 32'd12, 1'b1, 1'b1, 1'b1);
    chk("flush_valid", 32'(wb_valid), 32'd0);
    chk("flush_stall", 32'(issue_stall), 32'd0);
    chk("flush_err_count", 32'(err_count), 32'd1);
    chk("flush_overflow", 32'(overflow), 32'd1);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("flush_late_dropped", 32'(wb_valid), 32'd0);

    // Asynchronous reset with three entries queued.
    cyc(1'b1, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd2, 32'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd3, 32'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd3, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(wb_valid), 32'd1);
    @(negedge clk);
    valid_in = 1'b0; wb_ready = 1'b0; error = 1'b0; flush = 1'b0;
    rst_l = 1'b0;
    #1;
    chk("async_rst_valid", 32'(wb_valid), 32'd0);
    chk("async_rst_rd", 32'(wb_rd), 32'd0);
    chk("async_rst_stall", 32'(issue_stall), 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    chk("async_rst_err_count", 32'(err_count), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_l = 1'b1;

    // Randomized traffic, mostly protocol-respecting with occasional stall violations.
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic [4:0] rd;
      v  = !m_stall() ? 1'($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 49) == 0);
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(v, rd, $urandom, 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
      check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
